// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan scheduler for a shared BCD-to-7-segment decoder with gap insertion,
// leading-zero blanking and frame-aligned load/ack. Optional PWM dimming under SEG_SCAN_DIM_EN.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]              brightness,
`endif
  output logic                    load_ack,
  output logic [3:0]              dig_code,
  output logic [NUM_DIGITS-1:0]   dig_an,
  output logic                    frame_start
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LastTick = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StScan, StGap} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DIV_W-1:0]        presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_vld_q, pend_vld_d;

  logic                    load_ack_d, frame_start_d;
  logic [3:0]              dig_code_d;
  logic [NUM_DIGITS-1:0]   dig_an_d;

  logic                    enter_scan;
  logic                    apply;
  logic                    an_on;

  // Invalid nibbles blank; digit i>0 blanks when it and every higher nibble is zero.
  function automatic logic [3:0] eff_code(input logic [4*NUM_DIGITS-1:0] val,
                                          input logic [IdxW-1:0]         sel,
                                          input logic                    lz);
    logic       upper_zero;
    logic [3:0] nib;
    logic [3:0] res;
    upper_zero = 1'b1;
    res        = 4'hF;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib        = val[4*i +: 4];
      upper_zero = upper_zero && (nib == 4'h0);
      if (sel == IdxW'(i)) begin
        if (nib > 4'd9) begin
          res = 4'hF;
        end else if (lz && (i != 0) && upper_zero) begin
          res = 4'hF;
        end else begin
          res = nib;
        end
      end
    end
    return res;
  endfunction

`ifdef SEG_SCAN_DIM_EN
  logic [2:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + 3'd1;
  // Anode register is loaded with pwm_d, matching the counter value visible in that cycle.
  assign an_on = (pwm_d <= brightness);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q <= 3'd0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  assign an_on = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      presc_q     <= '0;
      active_q    <= '1;
      pending_q   <= '1;
      pend_vld_q  <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      dig_code    <= 4'hF;
      dig_an      <= '1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      presc_q     <= presc_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_vld_q  <= pend_vld_d;
      load_ack    <= load_ack_d;
      frame_start <= frame_start_d;
      dig_code    <= dig_code_d;
      dig_an      <= dig_an_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    presc_d    = presc_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    enter_scan = 1'b0;
    apply      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          active_d   = bcd_in;
          state_d    = StScan;
          idx_d      = '0;
          presc_d    = '0;
          enter_scan = 1'b1;
          apply      = 1'b1;
        end
      end
      StScan: begin
        if (presc_q == LastTick) begin
          presc_d = '0;
          state_d = StGap;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      StGap: begin
        state_d    = StScan;
        enter_scan = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d = '0;
          if (pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
            apply      = 1'b1;
          end
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A load taken at a boundary lands in pending after the old pending was applied.
    if (load && (state_q != StIdle)) begin
      pending_d  = bcd_in;
      pend_vld_d = 1'b1;
    end
  end

  // Output logic, registered alongside the state.
  always_comb begin
    load_ack_d    = apply;
    frame_start_d = enter_scan && (idx_d == '0);
    dig_code_d    = 4'hF;
    dig_an_d      = '1;
    if (state_d == StScan) begin
      dig_code_d      = enter_scan ? eff_code(active_d, idx_d, blank_lz) : dig_code;
      dig_an_d[idx_d] = ~an_on;
    end
  end

endmodule
